// File: rtl/npxl_receiver.sv
// npxl_receiver: WS2812 single-wire decoder.
// Measures synchronized high-pulse widths, rebuilds 24-bit GRB words,
// strobes each word with its LED index and flags the latch gap that ends a frame.
module npxl_receiver #(
  parameter int LEDS         = 20,
  parameter int BIT_THRESH   = 29,
  parameter int MIN_HIGH     = 6,
  parameter int MAX_HIGH     = 60,
  parameter int LATCH_CYCLES = 2400
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_npxl_data,
  output logic [23:0]               o_color_data,
  output logic                      o_color_valid,
  output logic [$clog2(LEDS)-1:0]   o_led_idx,
  output logic                      o_frame_done,
  output logic [$clog2(LEDS+1)-1:0] o_led_count,
  output logic                      o_err,
  output logic                      o_busy
);

  localparam int IDXW = $clog2(LEDS);
  localparam int CNTW = $clog2(LEDS + 1);
  localparam int HW   = $clog2(MAX_HIGH + 2);
  localparam int LW   = $clog2(LATCH_CYCLES + 1);

  localparam logic [HW-1:0]   MIN_H    = HW'(MIN_HIGH);
  localparam logic [HW-1:0]   MAX_H    = HW'(MAX_HIGH);
  localparam logic [HW-1:0]   HIGH_SAT = HW'(MAX_HIGH + 1);
  localparam logic [HW-1:0]   THRESH   = HW'(BIT_THRESH);
  localparam logic [LW-1:0]   LATCH_M1 = LW'(LATCH_CYCLES - 1);
  localparam logic [LW-1:0]   LATCH_C  = LW'(LATCH_CYCLES);
  localparam logic [CNTW-1:0] LEDS_C   = CNTW'(LEDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  // Input synchronizer plus one history stage for edge detection
  logic sync1_q, sync2_q, sync3_q;
  logic rise, fall;

  state_t          state_q,      state_d;
  logic [HW-1:0]   high_cnt_q,   high_cnt_d;
  logic [LW-1:0]   low_cnt_q,    low_cnt_d;
  logic [23:0]     shift_q,      shift_d;
  logic [4:0]      bit_cnt_q,    bit_cnt_d;
  logic [CNTW-1:0] led_cnt_q,    led_cnt_d;
  logic [23:0]     color_data_q, color_data_d;
  logic            color_vld_q,  color_vld_d;
  logic [IDXW-1:0] led_idx_q,    led_idx_d;
  logic            frame_done_q, frame_done_d;
  logic [CNTW-1:0] led_count_q,  led_count_d;
  logic            err_q,        err_d;
  logic            busy_q,       busy_d;

  // Two-flop synchronizer followed by the edge history register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= i_npxl_data;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;
  assign fall = ~sync2_q & sync3_q;

  // Next-state logic: word completion runs independently of the pulse FSM
  always_comb begin
    state_d      = state_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    led_cnt_d    = led_cnt_q;
    color_data_d = color_data_q;
    color_vld_d  = 1'b0;
    led_idx_d    = led_idx_q;
    frame_done_d = 1'b0;
    led_count_d  = led_count_q;
    err_d        = err_q;
    busy_d       = busy_q;

    // A full word is published one cycle after its last bit was shifted in;
    // the counter reset below lets a same-cycle bit shift build on zero.
    if (bit_cnt_q == 5'd24) begin
      bit_cnt_d = '0;
      if (led_cnt_q < LEDS_C) begin
        color_data_d = shift_q;
        led_idx_d    = led_cnt_q[IDXW-1:0];
        color_vld_d  = 1'b1;
        led_cnt_d    = led_cnt_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          shift_d     = '0;
          bit_cnt_d   = '0;
          led_cnt_d   = '0;
          led_count_d = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          // The rise cycle itself is the first high cycle, so the count
          // on the falling edge equals the synchronized pulse width.
          high_cnt_d  = HW'(1);
          state_d     = S_HIGH;
        end
      end

      S_HIGH: begin
        if (fall) begin
          if (high_cnt_q < MIN_H || high_cnt_q > MAX_H) begin
            err_d = 1'b1;
          end else begin
            shift_d   = {shift_q[22:0], (high_cnt_q >= THRESH)};
            bit_cnt_d = bit_cnt_d + 1'b1;
          end
          low_cnt_d = '0;
          state_d   = S_LOW;
        end else if (high_cnt_q != HIGH_SAT) begin
          high_cnt_d = high_cnt_q + 1'b1;
          // Stuck-high flagged once, when the count crosses the limit
          if (high_cnt_q == MAX_H) begin
            err_d = 1'b1;
          end
        end
      end

      S_LOW: begin
        if (rise) begin
          high_cnt_d = HW'(1);
          state_d    = S_HIGH;
        end else if (low_cnt_q == LATCH_M1) begin
          low_cnt_d    = LATCH_C;
          frame_done_d = 1'b1;
          led_count_d  = led_cnt_q;
          busy_d       = 1'b0;
          if (bit_cnt_q != '0) begin
            err_d = 1'b1;
          end
          bit_cnt_d    = '0;
          state_d      = S_IDLE;
        end else if (low_cnt_q != LATCH_C) begin
          low_cnt_d = low_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      led_cnt_q    <= '0;
      color_data_q <= '0;
      color_vld_q  <= 1'b0;
      led_idx_q    <= '0;
      frame_done_q <= 1'b0;
      led_count_q  <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      led_cnt_q    <= led_cnt_d;
      color_data_q <= color_data_d;
      color_vld_q  <= color_vld_d;
      led_idx_q    <= led_idx_d;
      frame_done_q <= frame_done_d;
      led_count_q  <= led_count_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign o_color_data  = color_data_q;
  assign o_color_valid = color_vld_q;
  assign o_led_idx     = led_idx_q;
  assign o_frame_done  = frame_done_q;
  assign o_led_count   = led_count_q;
  assign o_err         = err_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_npxl_receiver.sv
// tb_npxl_receiver: drives WS2812 waveforms into npxl_receiver and checks
// decoded words against a scoreboard, plus frame/latch/error behaviour.
`timescale 1ns/1ps
module tb_npxl_receiver;

  localparam int HI1    = 38;  // ~0.8 us at 48 MHz
  localparam int HI0    = 19;  // ~0.4 us
  localparam int PERIOD = 45;

  logic        clk;
  logic        rst_n;
  logic        pin;
  logic [23:0] color_data;
  logic        color_valid;
  logic [4:0]  led_idx;
  logic        frame_done;
  logic [4:0]  led_count;
  logic        err;
  logic        busy;

  typedef struct {
    logic [4:0]  idx;
    logic [23:0] data;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fall_cyc = 0;
  int valid_cyc = 0;

  npxl_receiver #(
    .LEDS(20),
    .BIT_THRESH(29),
    .MIN_HIGH(6),
    .MAX_HIGH(60),
    .LATCH_CYCLES(2400)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_npxl_data  (pin),
    .o_color_data (color_data),
    .o_color_valid(color_valid),
    .o_led_idx    (led_idx),
    .o_frame_done (frame_done),
    .o_led_count  (led_count),
    .o_err        (err),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #10.417 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && color_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("word_data", color_data, e.data);
        check_eq("word_idx", led_idx, e.idx);
        valid_cyc = cyc;
      end
    end
  end

  task automatic send_bit(input logic b);
    int hi;
    hi = b ? HI1 : HI0;
    pin = 1'b1;
    repeat (hi) @(posedge clk);
    #1 pin = 1'b0;
    fall_cyc = cyc;
    repeat (PERIOD - hi) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] w, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) send_bit(w[i]);
  endtask

  task automatic send_word(input logic [23:0] w, input logic expect_it, input logic [4:0] idx);
    exp_t e;
    if (expect_it) begin
      e.idx  = idx;
      e.data = w;
      sb.push_back(e);
    end
    send_bits(w, 24);
  endtask

  task automatic glitch();
    pin = 1'b1;
    repeat (3) @(posedge clk);
    #1 pin = 1'b0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  // Holds the line low and waits (bounded) for the latch strobe
  task automatic expect_frame(input logic [4:0] cnt, input logic e);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    pin = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (frame_done) seen = 1'b1;
    end
    check_eq("frame_done_seen", seen, 1);
    if (seen) begin
      check_eq("latch_gap", (n >= 2300 && n <= 2500), 1);
      check_eq("led_count", led_count, cnt);
      check_eq("frame_err", err, e);
      check_eq("busy_at_done", busy, 0);
      @(negedge clk);
      check_eq("done_pulse", frame_done, 0);
      check_eq("err_hold", err, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dones;
    pin   = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             {color_data, color_valid, led_idx, frame_done, led_count, err, busy}, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single LED with latency check
    send_word(24'hA5F00F, 1'b1, 5'd0);
    check_eq("busy_mid", busy, 1);
    check_eq("latency", valid_cyc - fall_cyc, 4);
    expect_frame(5'd1, 1'b0);

    // Full frame of 20 LEDs
    for (int k = 0; k < 20; k++) send_word(24'(k * 24'h010101), 1'b1, 5'(k));
    expect_frame(5'd20, 1'b0);
    check_eq("busy_after", busy, 0);
    check_eq("data_hold", color_data, 24'h131313);
    check_eq("idx_hold", led_idx, 19);

    // Overflow: 21st word dropped with error
    for (int k = 0; k < 21; k++) send_word(24'(k * 24'h020304), (k < 20), 5'(k));
    expect_frame(5'd20, 1'b1);

    // Partial word, then a clean frame clears the error
    send_bits(24'hFFF000, 12);
    expect_frame(5'd0, 1'b1);
    send_word(24'h00FF00, 1'b1, 5'd0);
    expect_frame(5'd1, 1'b0);

    // Glitch mid-word is flagged and not counted as a bit
    sb.push_back('{idx: 5'd0, data: 24'h5A3C96});
    send_bits(24'h5A3C96, 12);
    glitch();
    check_eq("glitch_err", err, 1);
    send_bits({24'h5A3C96} << 12, 12);
    expect_frame(5'd1, 1'b1);

    // Stuck-high line
    send_word(24'h000001, 1'b1, 5'd0);
    expect_frame(5'd1, 1'b0);
    pin = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check_eq("stuck_err", err, 1);
    check_eq("stuck_busy", busy, 1);
    repeat (20) @(posedge clk);
    #1 pin = 1'b0;
    expect_frame(5'd0, 1'b1);

    // Reset mid-frame: after bit 10 of word 2
    send_word(24'h111111, 1'b1, 5'd0);
    send_word(24'h222222, 1'b1, 5'd1);
    send_bits(24'h333333, 11);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_outputs",
             {color_data, color_valid, led_idx, frame_done, led_count, err, busy}, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    repeat (2600) begin
      @(negedge clk);
      if (frame_done || color_valid) dones++;
    end
    check_eq("no_strobe_after_reset", dones, 0);
    @(posedge clk);
    #1;
    send_word(24'h123456, 1'b1, 5'd0);
    expect_frame(5'd1, 1'b0);

    check_eq("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
